// File: rtl/nba_delay_scheduler.sv
// nba_delay_scheduler: holds delayed register updates in a small slot pool.
// Each slot counts down. A slot commits its value to q on the edge where its
// counter moves from 1 to 0. When several slots expire on the same edge, the
// most recently accepted slot wins. A delay-0 request accepted on that edge
// beats every expiring slot.
module nba_delay_scheduler #(
   parameter int                DATA_W    = 8,
   parameter int                DELAY_W   = 4,
   parameter int                SLOTS     = 4,
   parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         req_valid,
   output logic                         req_ready,
   input  logic [DELAY_W-1:0]           req_delay,
   input  logic [DATA_W-1:0]            req_data,
   input  logic                         cancel,
   output logic [DATA_W-1:0]            q,
   output logic                         q_update,
   output logic [$clog2(SLOTS+1)-1:0]   pending_cnt
);

   localparam int                 CNT_W   = $clog2(SLOTS+1);
   localparam logic [CNT_W-1:0]   SLOTS_C = CNT_W'(SLOTS);
   localparam logic [DELAY_W-1:0] ONE     = DELAY_W'(1);

   // Per-slot state.
   // Bit j of older_reg[i] is set when slot i was accepted before slot j.
   logic                valid_reg [SLOTS];
   logic                valid_next[SLOTS];
   logic [DELAY_W-1:0]  cnt_reg   [SLOTS];
   logic [DELAY_W-1:0]  cnt_next  [SLOTS];
   logic [DATA_W-1:0]   data_reg  [SLOTS];
   logic [DATA_W-1:0]   data_next [SLOTS];
   logic [SLOTS-1:0]    older_reg [SLOTS];
   logic [SLOTS-1:0]    older_next[SLOTS];

   logic [DATA_W-1:0]   q_reg, q_next;
   logic                q_update_reg, q_update_next;
   logic [CNT_W-1:0]    pending_cnt_reg, pending_cnt_next;

   logic [SLOTS-1:0]    expire;
   logic [SLOTS-1:0]    newest;
   logic [DATA_W-1:0]   win_data;
   logic                accept;
   logic                alloc;
   int                  alloc_idx;

   // Ready depends only on the requested delay and the registered occupancy,
   // so a slot that expires this edge is not offered until the next one.
   assign req_ready   = (req_delay == '0) || (pending_cnt_reg < SLOTS_C);
   assign accept      = req_valid && req_ready;
   assign alloc       = accept && (req_delay != '0);
   assign q           = q_reg;
   assign q_update    = q_update_reg;
   assign pending_cnt = pending_cnt_reg;

   generate
      for (genvar gi = 0; gi < SLOTS; gi++) begin : g_expire
         assign expire[gi] = valid_reg[gi] && (cnt_reg[gi] == ONE);
      end
   endgenerate

   // Among the expiring slots, keep only the one no other expiring slot is newer than.
   always_comb begin
      newest = expire;
      for (int i = 0; i < SLOTS; i++) begin
         for (int j = 0; j < SLOTS; j++) begin
            if (j != i && expire[j] && !older_reg[j][i]) newest[i] = 1'b0;
         end
      end
   end

   // One-hot select of the winning slot's data.
   always_comb begin
      win_data = '0;
      for (int i = 0; i < SLOTS; i++) begin
         if (newest[i]) win_data = win_data | data_reg[i];
      end
   end

   // Lowest free slot. After a cancel every slot is free, so slot 0 is used.
   always_comb begin
      alloc_idx = 0;
      for (int i = SLOTS - 1; i >= 0; i--) begin
         if (!valid_reg[i]) alloc_idx = i;
      end
      if (cancel) alloc_idx = 0;
   end

   // Slot countdown, expiry, cancel and allocation, in that priority order.
   always_comb begin
      pending_cnt_next = '0;
      for (int i = 0; i < SLOTS; i++) begin
         valid_next[i] = valid_reg[i];
         cnt_next[i]   = cnt_reg[i];
         data_next[i]  = data_reg[i];
         if (valid_reg[i]) begin
            if (expire[i]) valid_next[i] = 1'b0;
            else           cnt_next[i]   = cnt_reg[i] - ONE;
         end
         if (cancel) valid_next[i] = 1'b0;
         if (alloc && i == alloc_idx) begin
            valid_next[i] = 1'b1;
            cnt_next[i]   = req_delay;
            data_next[i]  = req_data;
         end
         pending_cnt_next = pending_cnt_next + CNT_W'(valid_next[i]);
      end
   end

   // Age matrix update: a newly allocated slot is younger than every survivor.
   always_comb begin
      for (int i = 0; i < SLOTS; i++) begin
         older_next[i] = older_reg[i];
         if (alloc) begin
            for (int j = 0; j < SLOTS; j++) begin
               if (i == alloc_idx)      older_next[i][j] = 1'b0;
               else if (j == alloc_idx) older_next[i][j] = valid_next[i];
            end
         end
      end
   end

   // Output register write: a delay-0 accept wins over any expiring slot.
   always_comb begin
      q_next        = q_reg;
      q_update_next = 1'b0;
      if (accept && req_delay == '0) begin
         q_next        = req_data;
         q_update_next = 1'b1;
      end else if (!cancel && (|expire)) begin
         q_next        = win_data;
         q_update_next = 1'b1;
      end
   end

   // Output and occupancy registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_reg           <= RESET_VAL;
         q_update_reg    <= 1'b0;
         pending_cnt_reg <= '0;
      end else begin
         q_reg           <= q_next;
         q_update_reg    <= q_update_next;
         pending_cnt_reg <= pending_cnt_next;
      end
   end

   generate
      for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
         // Per-slot storage; reset frees the slot and drops its pending value.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               valid_reg[gi] <= 1'b0;
               cnt_reg[gi]   <= '0;
               data_reg[gi]  <= '0;
               older_reg[gi] <= '0;
            end else begin
               valid_reg[gi] <= valid_next[gi];
               cnt_reg[gi]   <= cnt_next[gi];
               data_reg[gi]  <= data_next[gi];
               older_reg[gi] <= older_next[gi];
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_nba_delay_scheduler.sv
// Bench for nba_delay_scheduler: directed requests push the expected q values
// into a queue in commit order; a monitor pops one entry per q_update pulse.
module tb_nba_delay_scheduler;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic [3:0] req_delay = '0;
   logic [7:0] req_data = '0;
   logic       cancel = 1'b0;
   logic [7:0] q;
   logic       q_update;
   logic [2:0] pending_cnt;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_q[$];

   nba_delay_scheduler #(.DATA_W(8), .DELAY_W(4), .SLOTS(4), .RESET_VAL(8'h00)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_delay   (req_delay),
      .req_data    (req_data),
      .cancel      (cancel),
      .q           (q),
      .q_update    (q_update),
      .pending_cnt (pending_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [3:0] d, input logic [7:0] v);
      req_valid = 1'b1;
      req_delay = d;
      req_data  = v;
      #1;
      chk("accept_ready", req_ready, 1);
      tick();
      req_valid = 1'b0;
      req_delay = '0;
      req_data  = '0;
   endtask

   // Scoreboard monitor: every q_update pulse must match the next expected value.
   initial begin
      logic [7:0] e;
      forever begin
         @(negedge clk);
         if (!rst && q_update) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL sb_unexpected_update: got q=%0h required no update", q);
            end else begin
               e = exp_q.pop_front();
               if (q !== e) begin
                  errors++;
                  $display("FAIL sb_commit: got q=%0h required %0h", q, e);
               end else begin
                  $display("ok   sb_commit: q=%0h", q);
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset state
      tick();
      tick();
      chk("rst_q", q, 8'h00);
      chk("rst_q_update", q_update, 0);
      chk("rst_pending", pending_cnt, 0);
      chk("rst_ready", req_ready, 1);
      rst = 1'b0;

      // 1: delay-0 then delay-3
      exp_q.push_back(8'h01);
      exp_q.push_back(8'h00);
      issue(4'd0, 8'h01);                 // edge 0
      chk("t1_q_e0", q, 8'h01);
      issue(4'd3, 8'h00);                 // edge 1
      tick();                             // edge 2
      tick();                             // edge 3
      chk("t1_pending_e3", pending_cnt, 1);
      chk("t1_q_e3", q, 8'h01);
      tick();                             // edge 4
      chk("t1_q_e4", q, 8'h00);
      chk("t1_upd_e4", q_update, 1);
      chk("t1_pending_e4", pending_cnt, 0);

      // 2: simultaneous expiry, later accept wins
      exp_q.push_back(8'h09);
      issue(4'd2, 8'h05);                 // edge 0
      issue(4'd1, 8'h09);                 // edge 1
      chk("t2_pending_e1", pending_cnt, 2);
      tick();                             // edge 2
      chk("t2_q_e2", q, 8'h09);
      chk("t2_pending_e2", pending_cnt, 0);
      tick();

      // 3: full pool, delay-0 still accepted
      exp_q.push_back(8'h55);
      for (int i = 0; i < 4; i++) exp_q.push_back(8'h10 + 8'(i));
      for (int i = 0; i < 4; i++) issue(4'd8, 8'h10 + 8'(i));
      chk("t3_pending_full", pending_cnt, 4);
      req_delay = 4'd8;
      #1;
      chk("t3_ready_full_d8", req_ready, 0);
      req_delay = 4'd0;
      #1;
      chk("t3_ready_full_d0", req_ready, 1);
      issue(4'd0, 8'h55);
      chk("t3_q_while_full", q, 8'h55);
      chk("t3_pending_still_full", pending_cnt, 4);
      repeat (10) tick();
      chk("t3_pending_drained", pending_cnt, 0);
      chk("t3_q_last", q, 8'h13);

      // Maximum delay commits exactly 15 edges after acceptance
      exp_q.push_back(8'h77);
      issue(4'd15, 8'h77);                // edge 0
      repeat (14) tick();                 // edge 14
      chk("max_pending_e14", pending_cnt, 1);
      chk("max_q_e14", q, 8'h13);
      tick();                             // edge 15
      chk("max_q_e15", q, 8'h77);
      chk("max_pending_e15", pending_cnt, 0);

      // 4: cancel drops a pending request
      issue(4'd4, 8'h03);                 // edge 0
      tick();                             // edge 1
      cancel = 1'b1;
      tick();                             // edge 2
      cancel = 1'b0;
      chk("t4_pending_e2", pending_cnt, 0);
      repeat (5) tick();
      chk("t4_q_kept", q, 8'h77);

      // Cancel with a same-edge accept: the new request survives in slot 0
      exp_q.push_back(8'h44);
      issue(4'd5, 8'h21);                 // edge 0
      cancel = 1'b1;
      issue(4'd2, 8'h44);                 // edge 1
      cancel = 1'b0;
      chk("cx_pending_e1", pending_cnt, 1);
      tick();                             // edge 2
      chk("cx_q_e2", q, 8'h77);
      tick();                             // edge 3
      chk("cx_q_e3", q, 8'h44);
      repeat (4) tick();
      chk("cx_pending_end", pending_cnt, 0);

      // 5: delay-0 beats an expiring slot on the same edge
      exp_q.push_back(8'h02);
      issue(4'd2, 8'h07);                 // edge 0
      tick();                             // edge 1
      issue(4'd0, 8'h02);                 // edge 2
      chk("t5_q_e2", q, 8'h02);
      chk("t5_pending_e2", pending_cnt, 0);
      tick();
      chk("t5_single_pulse", q_update, 0);

      // 6: asynchronous reset mid-countdown
      issue(4'd10, 8'hA1);
      issue(4'd10, 8'hA2);
      issue(4'd10, 8'hA3);
      chk("t6_pending_3", pending_cnt, 3);
      #3;
      rst = 1'b1;
      #1;
      chk("t6_async_q", q, 8'h00);
      chk("t6_async_pending", pending_cnt, 0);
      chk("t6_async_upd", q_update, 0);
      tick();
      rst = 1'b0;
      repeat (15) tick();
      chk("t6_q_after", q, 8'h00);
      chk("t6_pending_after", pending_cnt, 0);

      tick();
      tick();
      chk("sb_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
